// File: rtl/input_current_calc.sv
// Synaptic input-current stage: sums the signed weights of spiking inputs each
// enabled cycle, clamps to signed 8 bits and registers the result.
module input_current_calc #(
    parameter int M = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic [M-1:0]   input_spikes,
    input  logic [M*8-1:0] weights,
    output logic [7:0]     input_current
);

    // Wide enough that M worst-case weights of either sign never wrap.
    localparam int AW = 8 + $clog2(M) + 1;

    localparam logic signed [AW-1:0] SAT_HI = AW'(127);
    localparam logic signed [AW-1:0] SAT_LO = AW'(-128);

    logic signed [AW-1:0] sum;
    logic        [7:0]    sat_sum;
    logic        [7:0]    input_current_d;
    logic        [7:0]    input_current_q;

    always_comb begin
        logic [7:0] w;
        sum = '0;
        for (int i = 0; i < M; i++) begin
            w = weights[8*i +: 8];
            if (input_spikes[i]) begin
                sum = sum + {{(AW-8){w[7]}}, w};
            end
        end
    end

    always_comb begin
        sat_sum = sum[7:0];
        if (sum > SAT_HI) begin
            sat_sum = 8'h7F;
        end else if (sum < SAT_LO) begin
            sat_sum = 8'h80;
        end
    end

    always_comb begin
        input_current_d = input_current_q;
        if (enable) begin
            input_current_d = sat_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            input_current_q <= 8'h00;
        end else begin
            input_current_q <= input_current_d;
        end
    end

    assign input_current = input_current_q;

endmodule

// File: tb/tb_input_current_calc.sv
// Scoreboard bench for input_current_calc: stimulus pushes the model's expected
// output, an edge-driven monitor pops and compares one entry per clock.
module tb_input_current_calc;

    localparam int M = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           enable = 1'b0;
    logic [M-1:0]   input_spikes = '0;
    logic [M*8-1:0] weights = '0;
    logic [7:0]     input_current;

    always #5 clk = ~clk;

    input_current_calc #(.M(M)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .input_spikes  (input_spikes),
        .weights       (weights),
        .input_current (input_current)
    );

    typedef struct {
        string             name;
        logic signed [7:0] value;
    } exp_t;

    exp_t              exp_q[$];
    int                checks_total  = 0;
    int                checks_passed = 0;
    logic signed [7:0] model_out     = 8'sd0;

    function automatic int ref_sum(input logic [M-1:0] s, input logic [M*8-1:0] w);
        int total = 0;
        for (int i = 0; i < M; i++) begin
            if (s[i]) total += int'($signed(w[8*i +: 8]));
        end
        return total;
    endfunction

    function automatic logic signed [7:0] sat8(input int s);
        if (s > 127)  return 8'h7F;
        if (s < -128) return 8'h80;
        return 8'(s);
    endfunction

    function automatic logic [63:0] pack8(input int b7, b6, b5, b4, b3, b2, b1, b0);
        return {8'(b7), 8'(b6), 8'(b5), 8'(b4), 8'(b3), 8'(b2), 8'(b1), 8'(b0)};
    endfunction

    function automatic logic [M*8-1:0] rand_weights();
        logic [M*8-1:0] w;
        for (int i = 0; i < M; i++) begin
            case ($urandom_range(0, 5))
                0:       w[8*i +: 8] = 8'h7F;
                1:       w[8*i +: 8] = 8'h80;
                default: w[8*i +: 8] = 8'($urandom);
            endcase
        end
        return w;
    endfunction

    task automatic apply_stimulus(input string name, input logic rst, input logic en,
                                  input logic [M-1:0] s, input logic [M*8-1:0] w);
        exp_t e;
        @(negedge clk);
        reset        = rst;
        enable       = en;
        input_spikes = s;
        weights      = w;
        if (!rst)    model_out = 8'sd0;
        else if (en) model_out = sat8(ref_sum(s, w));
        e.name  = name;
        e.value = model_out;
        exp_q.push_back(e);
    endtask

    task automatic check_output();
        exp_t e;
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        checks_total++;
        if ($signed(input_current) === e.value) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: input_current=%0d (0x%h) expected %0d (0x%h)",
                     e.name, $signed(input_current), input_current, e.value, e.value);
        end
    endtask

    // Outputs settle after the edge, so compare just past it.
    always @(posedge clk) begin
        #1;
        check_output();
    end

    initial begin
        logic [63:0] w_inc, w_alt, w_can, w_p100, w_m100;
        w_inc  = pack8(10, 20, 30, 40, 50, 60, 70, 80);
        w_alt  = pack8(10, -20, 30, -40, 50, -60, 70, -80);
        w_can  = pack8(100, -100, 50, -50, 25, -25, 12, -12);
        w_p100 = pack8(100, 100, 100, 100, 100, 100, 100, 100);
        w_m100 = pack8(-100, -100, -100, -100, -100, -100, -100, -100);

        apply_stimulus("reset_en_high",  1'b0, 1'b1, 8'hFF, rand_weights());
        apply_stimulus("reset_hold",     1'b1, 1'b0, 8'hFF, rand_weights());
        apply_stimulus("no_spikes",      1'b1, 1'b1, 8'h00, w_inc);
        apply_stimulus("pos_sat_360",    1'b1, 1'b1, 8'hFF, w_inc);
        apply_stimulus("pos_sat_800",    1'b1, 1'b1, 8'hFF, w_p100);
        apply_stimulus("pos_sat_mixed",  1'b1, 1'b1, 8'hAA, w_alt);
        apply_stimulus("neg_sat_800",    1'b1, 1'b1, 8'hFF, w_m100);
        apply_stimulus("mixed_neg60",    1'b1, 1'b1, 8'h50, w_alt);
        apply_stimulus("cancel_zero",    1'b1, 1'b1, 8'hCC, w_can);
        for (int k = 0; k < 4; k++)
            apply_stimulus("hold_disabled", 1'b1, 1'b0, 8'($urandom), rand_weights());
        apply_stimulus("reenable_sat",   1'b1, 1'b1, 8'hFF, w_p100);
        apply_stimulus("exact_127",      1'b1, 1'b1, 8'h03, pack8(0, 0, 0, 0, 0, 0, 27, 100));
        apply_stimulus("exact_128",      1'b1, 1'b1, 8'h03, pack8(0, 0, 0, 0, 0, 0, 28, 100));
        apply_stimulus("exact_m128",     1'b1, 1'b1, 8'h03, pack8(0, 0, 0, 0, 0, 0, -28, -100));
        apply_stimulus("exact_m129",     1'b1, 1'b1, 8'h03, pack8(0, 0, 0, 0, 0, 0, -29, -100));
        apply_stimulus("single_weight",  1'b1, 1'b1, 8'h10, pack8(1, 2, 3, -77, 5, 6, 7, 8));
        apply_stimulus("reset_mid_op",   1'b0, 1'b1, 8'hFF, w_inc);
        apply_stimulus("after_reset",    1'b1, 1'b0, 8'hFF, w_inc);

        for (int k = 0; k < 300; k++) begin
            apply_stimulus("random",
                           ($urandom_range(0, 15) != 0),
                           ($urandom_range(0, 3) != 0),
                           8'($urandom),
                           rand_weights());
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks_total++;
            $display("[TB] FAIL drain: pending=%0d expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
